// File: rtl/and_gate.sv
// Bitwise two-input AND with a combinational result and a registered monitor:
// a one-cycle delayed copy of the result plus a saturating count of y_all rises.
module and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_all,
  output logic [CNT_W-1:0] rise_cnt
);

  logic             y_all_d_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rise;

  // Combinational path never touches clk or rst_n.
  assign y     = a & b;
  assign y_all = &y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_all_d_q <= 1'b0;
    end else begin
      y_q       <= y;
      y_all_d_q <= y_all;
    end
  end

  // Clear beats a simultaneous rise; the count sticks at all-ones.
  always_comb begin
    rise  = y_all & ~y_all_d_q;
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (rise && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rise_cnt = cnt_q;

endmodule

// File: tb/tb_and_gate.sv
// Bench for and_gate: three instances (WIDTH=1, WIDTH=8, WIDTH=1 with CNT_W=2)
// checked against a truth-table / event-counting reference model.
module tb_and_gate;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n;

  logic       a1, b1, clr1, clr_s, clr8;
  logic [7:0] a8, b8;

  logic        y1, yq1, yall1;
  logic [15:0] cnt1;
  logic        ys, yqs, yalls;
  logic [1:0]  cnts;
  logic [7:0]  y8, yq8;
  logic        yall8;
  logic [15:0] cnt8;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic       m_yq1, m_prev1, m_yq8_all, m_prev8;
  logic [7:0] m_yq8;
  int         m_cnt1, m_cnts, m_cnt8;

  and_gate #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cnt_clr(clr1),
    .y(y1), .y_q(yq1), .y_all(yall1), .rise_cnt(cnt1)
  );

  and_gate #(.WIDTH(8), .CNT_W(16)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cnt_clr(clr8),
    .y(y8), .y_q(yq8), .y_all(yall8), .rise_cnt(cnt8)
  );

  and_gate #(.WIDTH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cnt_clr(clr_s),
    .y(ys), .y_q(yqs), .y_all(yalls), .rise_cnt(cnts)
  );

  always #5 if (clk_en) clk = ~clk;

  function automatic logic and_ref(input logic x, input logic z);
    logic [3:0] lut;
    lut = 4'b1000;
    return lut[{x, z}];
  endfunction

  function automatic logic [7:0] and8_ref(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = and_ref(x[i], z[i]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_yq1 = 1'b0; m_prev1 = 1'b0; m_cnt1 = 0; m_cnts = 0;
    m_yq8 = 8'h00; m_prev8 = 1'b0; m_cnt8 = 0;
  endtask

  task automatic check_comb();
    check("y_w1", 32'(y1), 32'(and_ref(a1, b1)));
    check("y_sat", 32'(ys), 32'(and_ref(a1, b1)));
    check("y_w8", 32'(y8), 32'(and8_ref(a8, b8)));
    check("y_all_w8", 32'(yall8), 32'(and8_ref(a8, b8) == 8'hFF));
  endtask

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic cycle();
    logic all1, all8, rise1, rise8;
    @(posedge clk);
    if (rst_n) begin
      all1  = and_ref(a1, b1);
      all8  = (and8_ref(a8, b8) == 8'hFF);
      rise1 = all1 && !m_prev1;
      rise8 = all8 && !m_prev8;
      m_yq1 = all1;
      m_yq8 = and8_ref(a8, b8);
      m_prev1 = all1;
      m_prev8 = all8;
      if (clr1) m_cnt1 = 0; else if (rise1 && m_cnt1 < 65535) m_cnt1++;
      if (clr_s) m_cnts = 0; else if (rise1 && m_cnts < 3) m_cnts++;
      if (clr8) m_cnt8 = 0; else if (rise8 && m_cnt8 < 65535) m_cnt8++;
    end
    @(negedge clk);
    check("y_q_w1", 32'(yq1), 32'(m_yq1));
    check("rise_cnt_w1", 32'(cnt1), 32'(m_cnt1));
    check("y_q_sat", 32'(yqs), 32'(m_yq1));
    check("rise_cnt_sat", 32'(cnts), 32'(m_cnts));
    check("y_q_w8", 32'(yq8), 32'(m_yq8));
    check("rise_cnt_w8", 32'(cnt8), 32'(m_cnt8));
  endtask

  initial begin
    logic [1:0] ab;
    rst_n = 1'b1;
    a1 = 1'b0; b1 = 1'b0; clr1 = 1'b0; clr_s = 1'b0; clr8 = 1'b0;
    a8 = 8'h00; b8 = 8'h00;
    reset_model();
    #1 rst_n = 1'b0;
    #1;
    check("reset_y_q", 32'(yq1), 32'd0);
    check("reset_rise_cnt", 32'(cnt1), 32'd0);
    check("reset_y_q_w8", 32'(yq8), 32'd0);

    // Truth table with the clock idle and reset asserted
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a1 = ab[1]; b1 = ab[0];
      #10;
      check("truth_y", 32'(y1), 32'(i == 3));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a1 = ab[1]; b1 = ab[0];
      #10;
      check("truth_y_rst_hi", 32'(y1), 32'(i == 3));
    end
    if (n_err != 0) begin
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "FAIL truth_table: aborting after combinational errors");
    end

    a8 = 8'hF0; b8 = 8'h3C; #1;
    check("w8_and", 32'(y8), 32'h30);
    check("w8_all0", 32'(yall8), 32'd0);
    a8 = 8'hFF; b8 = 8'hFF; #1;
    check("w8_all1", 32'(yall8), 32'd1);
    a8 = 8'h00; b8 = 8'h00; a1 = 1'b0; b1 = 1'b0;

    // Fresh reset, then start the clock
    rst_n = 1'b0; #1;
    reset_model();
    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(); cycle();

    // Latency: y immediate, y_q one edge later
    a1 = 1'b1; b1 = 1'b1; #1;
    check("lat_y_now", 32'(y1), 32'd1);
    check("lat_yq_before", 32'(yq1), 32'd0);
    cycle();
    check("lat_yq_after", 32'(yq1), 32'd1);
    b1 = 1'b0; #1;
    check("fall_y_now", 32'(y1), 32'd0);
    check("fall_yq_held", 32'(yq1), 32'd1);
    cycle();
    check("fall_yq_after", 32'(yq1), 32'd0);

    // 5-cycle pulse counts once, then a single-cycle pulse
    b1 = 1'b1;
    repeat (5) cycle();
    b1 = 1'b0; cycle();
    b1 = 1'b1; cycle();
    b1 = 1'b0; cycle();
    check("rise_cnt_three", 32'(cnt1), 32'd3);

    // Clear coincident with a rise
    b1 = 1'b1; clr1 = 1'b1; cycle();
    check("clr_wins", 32'(cnt1), 32'd0);
    clr1 = 1'b0;
    b1 = 1'b0; cycle();
    b1 = 1'b1; cycle();
    b1 = 1'b0; cycle();
    b1 = 1'b1; cycle();
    check("sat_sticks", 32'(cnts), 32'd3);
    check("pre_rst_cnt", 32'(cnt1), 32'd2);
    check("pre_rst_yq", 32'(yq1), 32'd1);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0; #1;
    reset_model();
    check("async_yq", 32'(yq1), 32'd0);
    check("async_cnt", 32'(cnt1), 32'd0);
    check("async_cnt_sat", 32'(cnts), 32'd0);
    check("async_y", 32'(y1), 32'd1);
    a1 = 1'b0; #1;
    check("async_y_track", 32'(y1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 1'b1;
    cycle();
    check("first_cycle_rise", 32'(cnt1), 32'd1);

    // Randomized phase
    for (int n = 0; n < 300; n++) begin
      a1 = ($urandom_range(0, 3) != 0);
      b1 = ($urandom_range(0, 3) != 0);
      clr1 = ($urandom_range(0, 15) == 0);
      clr_s = ($urandom_range(0, 31) == 0);
      clr8 = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0) begin
        a8 = 8'hFF; b8 = 8'hFF;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
      #1;
      check_comb();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
